// File: rtl/ctrl_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_pkg
//
// Shared definitions for the post-decode control pipeline.
//  - Default width of the control bundle carried by every stage.
//  - Bit positions of each named field inside that bundle.
//  - The per-stage update decision (bubble / hold / load) as an enum plus a
//    helper that resolves the flush > stall > upstream-held priority.
//
// Bundle layout (bit 12 is spare and travels through untouched):
//   [0]     Branch
//   [1]     Jump
//   [2]     RegWrite
//   [3]     MemWrite
//   [4]     ALUSrc
//   [6:5]   ResultSrc
//   [11:7]  ALUControl
// ---------------------------------------------------------------------------
package ctrl_pipe_pkg;

    localparam int CW_DEFAULT     = 13;

    localparam int BR_BIT_DEF     = 0;
    localparam int JMP_BIT_DEF    = 1;
    localparam int REGWRITE_BIT   = 2;
    localparam int MEMWRITE_BIT   = 3;
    localparam int ALUSRC_BIT     = 4;
    localparam int RESULTSRC_LSB  = 5;
    localparam int RESULTSRC_W    = 2;
    localparam int ALUCONTROL_LSB = 7;
    localparam int ALUCONTROL_W   = 5;

    // What a single stage register does on the next rising edge.
    typedef enum logic [1:0] {
        STAGE_HOLD   = 2'd0,
        STAGE_BUBBLE = 2'd1,
        STAGE_LOAD   = 2'd2
    } stage_op_e;

    // Flush beats a local hold, a local hold beats an upstream hold.  When the
    // upstream stage is holding, its contents stay put, so this stage must
    // take a bubble rather than a duplicate copy of the upstream instruction.
    function automatic stage_op_e stage_op(
        input logic flush,
        input logic hold,
        input logic up_held
    );
        stage_op_e op;
        if (flush) begin
            op = STAGE_BUBBLE;
        end else if (hold) begin
            op = STAGE_HOLD;
        end else if (up_held) begin
            op = STAGE_BUBBLE;
        end else begin
            op = STAGE_LOAD;
        end
        return op;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// ---------------------------------------------------------------------------
// ctrl_stage_reg
//
// One stage of the control pipeline: a CW-bit control bundle plus a valid
// bit.  Each rising edge the stage bubbles, holds, or loads from upstream as
// selected by ctrl_pipe_pkg::stage_op.  Whatever is loaded with valid=0 is
// stored as an all-zero bundle so invalid slots never carry a live RegWrite
// or MemWrite.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset (clears bundle and valid)
//   flush_i     insert a bubble this cycle (highest priority)
//   hold_i      keep the current contents
//   up_held_i   the upstream stage is holding this cycle
//   up_ctrl_i   upstream control bundle
//   up_valid_i  upstream valid bit
//   ctrl_o      registered control bundle
//   valid_o     registered valid bit
// ---------------------------------------------------------------------------
module ctrl_stage_reg
    import ctrl_pipe_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          hold_i,
    input  logic          up_held_i,
    input  logic [CW-1:0] up_ctrl_i,
    input  logic          up_valid_i,
    output logic [CW-1:0] ctrl_o,
    output logic          valid_o
);

    stage_op_e     op;
    logic [CW-1:0] stage_ctrl_d;
    logic [CW-1:0] stage_ctrl_q;
    logic          stage_valid_d;
    logic          stage_valid_q;

    // Next-state selection.  The loaded bundle is gated by the loaded valid
    // so a stage that picks up an empty slot ends up all-zero.
    always_comb begin
        op            = stage_op(flush_i, hold_i, up_held_i);
        stage_ctrl_d  = stage_ctrl_q;
        stage_valid_d = stage_valid_q;
        case (op)
            STAGE_BUBBLE: begin
                stage_ctrl_d  = '0;
                stage_valid_d = 1'b0;
            end
            STAGE_LOAD: begin
                stage_valid_d = up_valid_i;
                stage_ctrl_d  = up_valid_i ? up_ctrl_i : '0;
            end
            default: begin
                stage_ctrl_d  = stage_ctrl_q;
                stage_valid_d = stage_valid_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_ctrl_q  <= '0;
            stage_valid_q <= 1'b0;
        end else begin
            stage_ctrl_q  <= stage_ctrl_d;
            stage_valid_q <= stage_valid_d;
        end
    end

    assign ctrl_o  = stage_ctrl_q;
    assign valid_o = stage_valid_q;

endmodule

// File: rtl/ctrl_pipe_n.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_n
//
// Post-decode control pipeline of STAGES stages (stage 0 = EX, stage
// STAGES-1 = WB).  Carries the decoded control bundle alongside the datapath,
// applies the hazard unit's per-stage stall/flush requests, resolves the
// branch/jump decision in EX, counts retired instructions and flags stall
// patterns that would silently drop an instruction.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   ctrl_d      decoded control bundle from ID
//   valid_d     ID holds a real instruction
//   stall_d     ID is holding this cycle
//   stall       per-stage hold request (bit i = stage i)
//   flush       per-stage bubble request (bit i = stage i)
//   zero_e      ALU Zero flag of EX
//   ctrl_q      registered bundles, stage i at [i*CW +: CW]
//   valid_q     registered valid bit per stage
//   pcsrc_e     branch/jump taken, combinational from EX
//   retire_cnt  free-running count of retired instructions (wraps)
//   stall_err   sticky: a stage held while its upstream moved on
// ---------------------------------------------------------------------------
module ctrl_pipe_n
    import ctrl_pipe_pkg::*;
#(
    parameter int STAGES  = 3,
    parameter int CW      = CW_DEFAULT,
    parameter int BR_BIT  = BR_BIT_DEF,
    parameter int JMP_BIT = JMP_BIT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CW-1:0]        ctrl_d,
    input  logic                 valid_d,
    input  logic                 stall_d,
    input  logic [STAGES-1:0]    stall,
    input  logic [STAGES-1:0]    flush,
    input  logic                 zero_e,
    output logic [STAGES*CW-1:0] ctrl_q,
    output logic [STAGES-1:0]    valid_q,
    output logic                 pcsrc_e,
    output logic [31:0]          retire_cnt,
    output logic                 stall_err
);

    logic [STAGES-1:0][CW-1:0] stage_ctrl;
    logic [STAGES-1:0]         stage_valid;

    // up_held[i] is the hold request of whatever feeds stage i: ID for
    // stage 0, stage i-1 otherwise.
    logic [STAGES-1:0]         up_held;

    logic [31:0]               retire_cnt_d;
    logic [31:0]               retire_cnt_q;
    logic                      stall_err_d;
    logic                      stall_err_q;
    logic                      retire_fire;
    logic                      stall_bad;

    assign up_held = {stall[STAGES-2:0], stall_d};

    // One register per stage, chained so each stage loads from the one
    // before it; stage 0 loads straight from ID.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [CW-1:0] up_ctrl;
        logic          up_valid;

        if (i == 0) begin : g_first
            assign up_ctrl  = ctrl_d;
            assign up_valid = valid_d;
        end else begin : g_rest
            assign up_ctrl  = stage_ctrl[i-1];
            assign up_valid = stage_valid[i-1];
        end

        ctrl_stage_reg #(
            .CW (CW)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush_i    (flush[i]),
            .hold_i     (stall[i]),
            .up_held_i  (up_held[i]),
            .up_ctrl_i  (up_ctrl),
            .up_valid_i (up_valid),
            .ctrl_o     (stage_ctrl[i]),
            .valid_o    (stage_valid[i])
        );
    end

    assign ctrl_q  = stage_ctrl;
    assign valid_q = stage_valid;

    // Branch needs Zero from the ALU in the same cycle; Jump is unconditional.
    assign pcsrc_e = stage_valid[0]
                   & ((stage_ctrl[0][BR_BIT] & zero_e) | stage_ctrl[0][JMP_BIT]);

    // An instruction retires on the edge it leaves WB, so a held WB entry is
    // only counted once, when its hold drops.  The 32-bit add wraps freely.
    // A stage holding while its feeder keeps moving would overwrite nothing
    // but lose the feeder's instruction, hence the sticky error.
    always_comb begin
        retire_fire  = stage_valid[STAGES-1] & ~stall[STAGES-1];
        stall_bad    = |(stall & ~up_held);
        retire_cnt_d = retire_cnt_q;
        if (retire_fire) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
        stall_err_d  = stall_err_q | stall_bad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt_q <= '0;
            stall_err_q  <= 1'b0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            stall_err_q  <= stall_err_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign stall_err  = stall_err_q;

endmodule

// File: tb/tb_ctrl_pipe_n.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe_n
//
// Directed bench for ctrl_pipe_n with STAGES=3, CW=13.  Walks a single
// linear sequence: reset state, plain flow, load-use bubble, branch/jump
// resolution, flush-over-stall, held WB retire, illegal stall, counter wrap
// and asynchronous reset mid-stream.  Expected values are written by hand.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe_n;

    localparam int STAGES = 3;
    localparam int CW     = 13;

    logic                 clk;
    logic                 reset;
    logic [CW-1:0]        ctrl_d;
    logic                 valid_d;
    logic                 stall_d;
    logic [STAGES-1:0]    stall;
    logic [STAGES-1:0]    flush;
    logic                 zero_e;
    logic [STAGES*CW-1:0] ctrl_q;
    logic [STAGES-1:0]    valid_q;
    logic                 pcsrc_e;
    logic [31:0]          retire_cnt;
    logic                 stall_err;

    int total = 0;
    int bad   = 0;

    ctrl_pipe_n #(
        .STAGES  (STAGES),
        .CW      (CW),
        .BR_BIT  (0),
        .JMP_BIT (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl_d     (ctrl_d),
        .valid_d    (valid_d),
        .stall_d    (stall_d),
        .stall      (stall),
        .flush      (flush),
        .zero_e     (zero_e),
        .ctrl_q     (ctrl_q),
        .valid_q    (valid_q),
        .pcsrc_e    (pcsrc_e),
        .retire_cnt (retire_cnt),
        .stall_err  (stall_err)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive every DUT input at once.
    task automatic applyStimulus(
        input logic [CW-1:0]     c,
        input logic              v,
        input logic              sd,
        input logic [STAGES-1:0] st,
        input logic [STAGES-1:0] fl,
        input logic              z
    );
        ctrl_d  = c;
        valid_d = v;
        stall_d = sd;
        stall   = st;
        flush   = fl;
        zero_e  = z;
    endtask

    task automatic idle();
        applyStimulus('0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(
        input string       tag,
        input logic [63:0] observed,
        input logic [63:0] expected
    );
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [CW-1:0] stageCtrl(input int i);
        return ctrl_q[i*CW +: CW];
    endfunction

    // Single directed sequence.
    initial begin
        reset = 1'b0;
        idle();
        #2;
        checkOutput("rst_valid",  64'(valid_q),    64'h0);
        checkOutput("rst_ctrl",   64'(ctrl_q),     64'h0);
        checkOutput("rst_retire", 64'(retire_cnt), 64'h0);
        checkOutput("rst_err",    64'(stall_err),  64'h0);
        checkOutput("rst_pcsrc",  64'(pcsrc_e),    64'h0);
        tick();
        tick();
        reset = 1'b1;

        // Plain flow: one instruction marches EX -> MEM -> WB -> retired.
        applyStimulus(13'h0005, 1'b1, 1'b0, '0, '0, 1'b0);
        tick();
        checkOutput("c1_valid_ex", 64'(valid_q),     64'b001);
        checkOutput("c1_ctrl_ex",  64'(stageCtrl(0)), 64'h5);
        applyStimulus(13'h1FFF, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        checkOutput("c1_valid_mem",  64'(valid_q),     64'b010);
        checkOutput("c1_zero_gate",  64'(stageCtrl(0)), 64'h0);
        checkOutput("c1_ctrl_mem",   64'(stageCtrl(1)), 64'h5);
        idle();
        tick();
        checkOutput("c1_valid_wb",  64'(valid_q),     64'b100);
        checkOutput("c1_ctrl_wb",   64'(stageCtrl(2)), 64'h5);
        checkOutput("c1_retire_0",  64'(retire_cnt),  64'd0);
        tick();
        checkOutput("c1_valid_out", 64'(valid_q),    64'b000);
        checkOutput("c1_retire_1",  64'(retire_cnt), 64'd1);

        // Load-use: ID holds for one cycle, EX takes a bubble.
        applyStimulus(13'h0010, 1'b1, 1'b1, '0, '0, 1'b0);
        tick();
        checkOutput("c2_bubble_valid", 64'(valid_q),     64'b000);
        checkOutput("c2_bubble_ctrl",  64'(stageCtrl(0)), 64'h0);
        applyStimulus(13'h0010, 1'b1, 1'b0, '0, '0, 1'b0);
        tick();
        checkOutput("c2_enter_valid", 64'(valid_q),     64'b001);
        checkOutput("c2_enter_ctrl",  64'(stageCtrl(0)), 64'h10);

        // Branch in EX, taken only with Zero; invalid slot never redirects.
        applyStimulus(13'h0001, 1'b1, 1'b0, '0, '0, 1'b1);
        tick();
        checkOutput("c3_br_zero1", 64'(pcsrc_e), 64'h1);
        zero_e = 1'b0;
        #1;
        checkOutput("c3_br_zero0", 64'(pcsrc_e), 64'h0);
        applyStimulus(13'h0001, 1'b0, 1'b0, '0, '0, 1'b1);
        tick();
        checkOutput("c3_inv_valid", 64'(valid_q), 64'b110);
        checkOutput("c3_inv_pcsrc", 64'(pcsrc_e), 64'h0);
        applyStimulus(13'h0002, 1'b1, 1'b0, '0, '0, 1'b0);
        tick();
        checkOutput("c3_jmp_pcsrc",  64'(pcsrc_e),    64'h1);
        checkOutput("c3_jmp_valid",  64'(valid_q),    64'b101);
        checkOutput("c3_retire_2",   64'(retire_cnt), 64'd2);
        idle();
        tick();
        tick();
        tick();
        checkOutput("c3_retire_4", 64'(retire_cnt), 64'd4);
        checkOutput("c3_drained",  64'(valid_q),    64'b000);

        // Flush and stall together on EX: flush wins, no error.
        applyStimulus(13'h0004, 1'b1, 1'b0, '0, '0, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b1, 3'b001, 3'b001, 1'b0);
        tick();
        checkOutput("c4_flush_valid", 64'(valid_q),     64'b000);
        checkOutput("c4_flush_ctrl",  64'(stageCtrl(0)), 64'h0);
        checkOutput("c4_flush_err",   64'(stall_err),   64'h0);
        idle();
        tick();
        tick();
        tick();
        checkOutput("c4_no_retire", 64'(retire_cnt), 64'd4);

        // Legal hold on EX, then WB held for two cycles and counted once.
        applyStimulus(13'h0008, 1'b1, 1'b0, '0, '0, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b1, 3'b001, '0, 1'b0);
        tick();
        checkOutput("c4_hold_valid", 64'(valid_q),     64'b001);
        checkOutput("c4_hold_ctrl",  64'(stageCtrl(0)), 64'h8);
        checkOutput("c4_hold_err",   64'(stall_err),   64'h0);
        idle();
        tick();
        checkOutput("c4_mem_ctrl", 64'(stageCtrl(1)), 64'h8);
        tick();
        applyStimulus('0, 1'b0, 1'b1, 3'b111, '0, 1'b0);
        tick();
        checkOutput("c4_wbhold_valid", 64'(valid_q),    64'b100);
        checkOutput("c4_wbhold_cnt1",  64'(retire_cnt), 64'd4);
        tick();
        checkOutput("c4_wbhold_cnt2",  64'(retire_cnt), 64'd4);
        idle();
        tick();
        checkOutput("c4_wbleave_cnt",   64'(retire_cnt), 64'd5);
        checkOutput("c4_wbleave_valid", 64'(valid_q),    64'b000);

        // Illegal stall: MEM holds while EX moves on.
        applyStimulus('0, 1'b0, 1'b0, 3'b010, '0, 1'b0);
        tick();
        checkOutput("c5_err_set", 64'(stall_err), 64'h1);
        idle();
        tick();
        checkOutput("c5_err_sticky", 64'(stall_err), 64'h1);

        // Counter wrap at 0xFFFFFFFF.
        applyStimulus(13'h003F, 1'b1, 1'b0, '0, '0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        checkOutput("c6_preset", 64'(retire_cnt), 64'hFFFF_FFFF);
        tick();
        checkOutput("c6_wrap", 64'(retire_cnt), 64'h0);

        // Fill with jumps, then drop reset while clk is high.
        applyStimulus(13'h0002, 1'b1, 1'b0, '0, '0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        checkOutput("c6_full_valid",  64'(valid_q),    64'b111);
        checkOutput("c6_full_retire", 64'(retire_cnt), 64'd1);
        checkOutput("c6_full_pcsrc",  64'(pcsrc_e),    64'h1);
        checkOutput("c6_err_before",  64'(stall_err),  64'h1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("c6_arst_valid",  64'(valid_q),    64'h0);
        checkOutput("c6_arst_ctrl",   64'(ctrl_q),     64'h0);
        checkOutput("c6_arst_retire", 64'(retire_cnt), 64'h0);
        checkOutput("c6_arst_err",    64'(stall_err),  64'h0);
        checkOutput("c6_arst_pcsrc",  64'(pcsrc_e),    64'h0);

        // First edge after release loads.
        #4;
        reset = 1'b1;
        applyStimulus(13'h0005, 1'b1, 1'b0, '0, '0, 1'b0);
        tick();
        checkOutput("post_rst_valid", 64'(valid_q),     64'b001);
        checkOutput("post_rst_ctrl",  64'(stageCtrl(0)), 64'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_n.md
CTRL_PIPE_N -- requirements
Module: ctrl_pipe_n

Interface
REQ-001 The block SHALL have parameter STAGES, default 3, giving the number of post-decode control stages (index 0 = EX, index STAGES-1 = WB); legal range 2..8.
REQ-002 The block SHALL have parameter CW, default 13, giving the width of the control bundle carried per stage.
REQ-003 The block SHALL have parameter BR_BIT, default 0, giving the bundle bit position of the Branch flag.
REQ-004 The block SHALL have parameter JMP_BIT, default 1, giving the bundle bit position of the Jump flag.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 ctrl_d  in  CW  decoded control bundle from the ID stage.
REQ-008 valid_d  in  1  the ID stage holds a real instruction.
REQ-009 stall_d  in  1  the ID stage is holding this cycle.
REQ-010 stall  in  STAGES  per-stage hold request, bit i for stage i.
REQ-011 flush  in  STAGES  per-stage bubble-insert request, bit i for stage i.
REQ-012 zero_e  in  1  ALU Zero flag of the EX stage.
REQ-013 ctrl_q  out  STAGES*CW  registered bundles; stage i occupies bits [i*CW +: CW].
REQ-014 valid_q  out  STAGES  registered valid bit per stage.
REQ-015 pcsrc_e  out  1  branch/jump taken, resolved in EX.
REQ-016 retire_cnt  out  32  count of retired instructions.
REQ-017 stall_err  out  1  sticky flag for an illegal stall pattern.

Function
REQ-018 Each stage i SHALL update per cycle with priority: flush[i] -> bubble; else stall[i] -> hold; else upstream held (i=0: stall_d; i>0: stall[i-1]) -> bubble; else load upstream (i=0: ctrl_d/valid_d; i>0: stage i-1).
REQ-019 A bubble SHALL be valid_q=0 with the stage's ctrl_q all-zero.
REQ-020 Any stage whose loaded valid is 0 SHALL hold an all-zero ctrl_q, so that no RegWrite or MemWrite leaks from invalid slots.
REQ-021 Latency from ctrl_d to stage k SHALL be k+1 cycles with no stalls or flushes.
REQ-022 pcsrc_e SHALL be combinational: valid_q[0] & ((ctrl_q[0][BR_BIT] & zero_e) | ctrl_q[0][JMP_BIT]).
REQ-023 retire_cnt SHALL increment by 1 on each edge where valid_q[STAGES-1]=1 and stall[STAGES-1]=0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 A held WB instruction SHALL be counted once, on the cycle it leaves.
REQ-025 stall_err SHALL set on any edge where stall[0]=1 with stall_d=0, or stall[i]=1 with stall[i-1]=0 for i>0, because the upstream instruction would be lost.
REQ-026 stall_err SHALL clear only on reset.
REQ-027 When flush[i] and stall[i] are both set, flush SHALL win.
REQ-028 The block SHALL NOT add extra stall or flush propagation; the hazard unit owns those decisions.

Reset
REQ-029 While reset=0, the block SHALL asynchronously force ctrl_q, valid_q, retire_cnt and stall_err to 0, which also forces pcsrc_e to 0.
REQ-030 A reset asserted mid-operation SHALL discard all in-flight stages with no retire counted.
REQ-031 The first load after reset release SHALL occur on the first rising edge with reset=1.

Structure
REQ-032 Shared package ctrl_pipe_pkg SHALL hold the default CW, the BR_BIT/JMP_BIT constants and the named bit positions of RegWrite, MemWrite, ALUSrc, ResultSrc[1:0] and ALUControl[4:0].
REQ-033 One sub-module, ctrl_stage_reg, SHALL implement a single stage (flush/hold/bubble/load plus zero-gating) and SHALL be instantiated STAGES times by a generate loop.
REQ-034 Counter and error logic SHALL remain in the top level.

Verification
REQ-035 Case 1 (reset/flow): STAGES=3, valid_d=1, ctrl_d=0x0005 for one cycle, no stalls -> valid_q = 001, 010, 100 on successive cycles; retire_cnt=1 one cycle after WB.
REQ-036 Case 2 (load-use): stall_d=1 for one cycle -> stage 0 receives a bubble (valid_q[0]=0, ctrl_q[0]=0), and the ID instruction enters on the next cycle.
REQ-037 Case 3 (branch): stage 0 holds Branch=1, zero_e=1 -> pcsrc_e=1; with zero_e=0 -> 0; with valid_q[0]=0 -> 0.
REQ-038 Case 4 (flush vs stall): flush[0]=stall[0]=stall_d=1 -> stage 0 becomes a bubble; stall_err stays 0.
REQ-039 Case 5 (illegal stall): stall[1]=1 with stall[0]=0 -> stall_err=1 and holds until reset=0.
REQ-040 Case 6 (wrap/reset): with retire_cnt forced to 0xFFFFFFFF, one retire -> 0; reset=0 mid-stream -> all outputs 0 immediately, independent of clk.
